// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: engine FSM encoding and the
// bit offsets of the quotient and remainder inside the packed result word.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // The remainder occupies the low half of the result word.
  localparam int REM_LSB = 0;

  // The quotient sits directly above the remainder, so its LSB equals the operand width.
  function automatic int quot_lsb(input int width);
    return width;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division iteration resolving BITS_PER_CYCLE
// quotient bits. The quotient register doubles as the dividend shifter: its MSB
// feeds the partial remainder and each new quotient bit enters at its LSB.
module seq_divider_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] div_in,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_w;
  logic [WIDTH-1:0] quo_w;

  // Shift one dividend bit into the partial remainder and subtract the divisor when it fits.
  always_comb begin
    rem_w = rem_in;
    quo_w = quo_in;
    trial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      trial = {rem_w, quo_w[WIDTH-1]};
      quo_w = {quo_w[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, div_in}) begin
        trial    = trial - {1'b0, div_in};
        quo_w[0] = 1'b1;
      end
      rem_w = trial[WIDTH-1:0];
    end
    rem_out = rem_w;
    quo_out = quo_w;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider with AXI-Stream style operand and result channels.
// Each operand channel has a one-entry holding register so the next pair can be
// accepted while a division is running. Latency from the last operand transfer
// to result valid is WIDTH/BITS_PER_CYCLE + 2 cycles.
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's complement operands
// (quotient truncates toward zero, remainder follows the dividend sign);
// otherwise operands are unsigned. Latency is identical in both builds.
// WIDTH must be even and >= 8; BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_axis_divisor_tvalid,
  output logic                 s_axis_divisor_tready,
  input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
  input  logic                 s_axis_dividend_tvalid,
  output logic                 s_axis_dividend_tready,
  input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
  output logic                 m_axis_dout_tvalid,
  input  logic                 m_axis_dout_tready,
  output logic [2*WIDTH-1:0]   m_axis_dout_tdata,
  output logic                 m_axis_dout_tuser
);

  localparam int N        = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam int QUOT_LSB = quot_lsb(WIDTH);

  // Two's complement negate when requested; used both to take magnitudes and to restore signs.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               rdy_en;
  logic               dvd_full;
  logic               dsr_full;
  logic [WIDTH-1:0]   dvd_hold;
  logic [WIDTH-1:0]   dsr_hold;
  logic               dvd_xfer;
  logic               dsr_xfer;
  logic               start;
  logic               calc_last;
  logic               dvd_neg;
  logic               dsr_neg;

  logic [WIDTH-1:0]   eng_rem;
  logic [WIDTH-1:0]   eng_quo;
  logic [WIDTH-1:0]   eng_div;
  logic [WIDTH-1:0]   eng_dvd;
  logic               eng_qneg;
  logic               eng_rneg;
  logic               eng_zero;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  logic [2*WIDTH-1:0] out_data;
  logic               out_user;
  logic               out_valid;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic signed [WIDTH-1:0] dvd_sgn;
  logic signed [WIDTH-1:0] dsr_sgn;
  assign dvd_sgn = $signed(dvd_hold);
  assign dsr_sgn = $signed(dsr_hold);
  assign dvd_neg = (dvd_sgn < 0);
  assign dsr_neg = (dsr_sgn < 0);
`else
  assign dvd_neg = 1'b0;
  assign dsr_neg = 1'b0;
`endif

  // Ready is held low through reset and for the first edge after it via rdy_en.
  assign s_axis_dividend_tready = rdy_en & ~dvd_full;
  assign s_axis_divisor_tready  = rdy_en & ~dsr_full;
  assign dvd_xfer  = s_axis_dividend_tvalid & s_axis_dividend_tready;
  assign dsr_xfer  = s_axis_divisor_tvalid & s_axis_divisor_tready;
  assign start     = (state == ST_IDLE) & dvd_full & dsr_full;
  assign calc_last = (state == ST_CALC) && (cnt == CNT_W'(N - 1));

  // A zero divisor overrides the engine result; otherwise restore the signs of quotient and remainder.
  assign q_fix = eng_zero ? '1 : cond_neg(eng_quo, eng_qneg);
  assign r_fix = eng_zero ? eng_dvd : cond_neg(eng_rem, eng_rneg);

  seq_divider_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .rem_in  (eng_rem),
    .quo_in  (eng_quo),
    .div_in  (eng_div),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Control: holding-register occupancy, FSM sequencing and the iteration counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_en    <= 1'b0;
      dvd_full  <= 1'b0;
      dsr_full  <= 1'b0;
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (dvd_xfer) dvd_full <= 1'b1;
      else if (start) dvd_full <= 1'b0;
      if (dsr_xfer) dsr_full <= 1'b1;
      else if (start) dsr_full <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_CALC;
            cnt   <= '0;
          end
        end
        ST_CALC: begin
          cnt <= cnt + 1'b1;
          if (calc_last) state <= ST_FIX;
        end
        ST_FIX: begin
          state     <= ST_DONE;
          out_valid <= 1'b1;
        end
        default: begin
          if (m_axis_dout_tready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Datapath: capture operands, load magnitudes on start, iterate during CALC.
  always_ff @(posedge aclk) begin
    if (dvd_xfer) dvd_hold <= s_axis_dividend_tdata;
    if (dsr_xfer) dsr_hold <= s_axis_divisor_tdata;
    if (start) begin
      eng_rem  <= '0;
      eng_quo  <= cond_neg(dvd_hold, dvd_neg);
      eng_div  <= cond_neg(dsr_hold, dsr_neg);
      eng_dvd  <= dvd_hold;
      eng_qneg <= dvd_neg ^ dsr_neg;
      eng_rneg <= dvd_neg;
      eng_zero <= (dsr_hold == '0);
    end else if (state == ST_CALC) begin
      eng_rem <= step_rem;
      eng_quo <= step_quo;
    end
  end

  // Result register: packed once in FIX and held unchanged until the next FIX.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_data <= '0;
      out_user <= 1'b0;
    end else if (state == ST_FIX) begin
      out_data[QUOT_LSB +: WIDTH] <= q_fix;
      out_data[REM_LSB +: WIDTH]  <= r_fix;
      out_user                    <= eng_zero;
    end
  end

  assign m_axis_dout_tvalid = out_valid;
  assign m_axis_dout_tdata  = out_data;
  assign m_axis_dout_tuser  = out_user;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=64, BITS_PER_CYCLE=1). Directed
// vectors push expected results; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_seq_divider;

  localparam int WIDTH = 64;
  localparam int BPC   = 1;
  localparam int N     = WIDTH / BPC;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         dsr_valid = 1'b0;
  logic         dsr_ready;
  logic [63:0]  dsr_data = '0;
  logic         dvd_valid = 1'b0;
  logic         dvd_ready;
  logic [63:0]  dvd_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         out_user;

  seq_divider #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BPC)) dut (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .s_axis_divisor_tvalid  (dsr_valid),
    .s_axis_divisor_tready  (dsr_ready),
    .s_axis_divisor_tdata   (dsr_data),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tready (dvd_ready),
    .s_axis_dividend_tdata  (dvd_data),
    .m_axis_dout_tvalid     (out_valid),
    .m_axis_dout_tready     (out_ready),
    .m_axis_dout_tdata      (out_data),
    .m_axis_dout_tuser      (out_user)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        u;
    int          cyc;
    bit          rel;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_res(input logic [63:0] q, input logic [63:0] r, input logic u,
                            input int c, input bit rel);
    exp_t e;
    e.q = q; e.r = r; e.u = u; e.cyc = c; e.rel = rel;
    sb.push_back(e);
  endtask

  // Monitor: pop on each new result, check hold stability while stalled.
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [127:0] held_data = '0;
  logic         held_user = 1'b0;
  int           last_hs = 0;
  exp_t         mon_e;

  always @(negedge aclk) begin
    if (out_valid) begin
      if (!prev_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got q=0x%0h r=0x%0h, expected no result",
                   out_data[127:64], out_data[63:0]);
        end else begin
          mon_e = sb.pop_front();
          check("quotient", {64'd0, out_data[127:64]}, {64'd0, mon_e.q});
          check("remainder", {64'd0, out_data[63:0]}, {64'd0, mon_e.r});
          check("tuser", {127'd0, out_user}, {127'd0, mon_e.u});
          if (mon_e.rel) check("latency_after_handshake", 128'(cyc), 128'(last_hs + N + 2));
          else if (mon_e.cyc >= 0) check("latency", 128'(cyc), 128'(mon_e.cyc));
        end
      end else if (!prev_ready) begin
        check("stall_tdata_stable", out_data, held_data);
        check("stall_tuser_stable", {127'd0, out_user}, {127'd0, held_user});
      end
      if (out_ready) last_hs = cyc + 1;
    end
    held_data  = out_data;
    held_user  = out_user;
    prev_valid = out_valid;
    prev_ready = out_ready;
  end

  // Offer operands on the selected channels; h returns the edge of the last transfer.
  task automatic send(input bit use_dvd, input logic [63:0] dvd, input bit use_dsr,
                      input logic [63:0] dsr, output int h);
    bit a_dvd, a_dsr;
    int guard;
    @(posedge aclk); #1;
    if (use_dvd) begin dvd_valid = 1'b1; dvd_data = dvd; end
    if (use_dsr) begin dsr_valid = 1'b1; dsr_data = dsr; end
    guard = 0;
    h = -1;
    while ((dvd_valid || dsr_valid) && guard < 300) begin
      @(negedge aclk);
      a_dvd = dvd_valid && dvd_ready;
      a_dsr = dsr_valid && dsr_ready;
      @(posedge aclk); #1;
      if (a_dvd) dvd_valid = 1'b0;
      if (a_dsr) dsr_valid = 1'b0;
      if (a_dvd || a_dsr) h = cyc;
      guard++;
    end
    if (dvd_valid || dsr_valid) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no transfer in %0d cycles, expected transfer", guard);
      dvd_valid = 1'b0;
      dsr_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || out_valid) && g < 400) begin
      @(posedge aclk); #1;
      g++;
    end
    if (sb.size() != 0 || out_valid) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  logic [63:0] vec [6][4];
  int h, h2, hx, g;

  initial begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    vec[0] = '{64'd12345678901, 64'd1000, 64'd12345678, 64'd901};
    vec[1] = '{ONES, 64'd1, ONES, 64'd0};
    vec[2] = '{ONES, ONES, 64'd1, 64'd0};
    vec[3] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, ONES};
    vec[4] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1};
    vec[5] = '{MIN, ONES, MIN, 64'd0};
`else
    vec[0] = '{64'd12345678901, 64'd1000, 64'd12345678, 64'd901};
    vec[1] = '{ONES, 64'd1, ONES, 64'd0};
    vec[2] = '{ONES, ONES, 64'd1, 64'd0};
    vec[3] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'h7FFF_FFFF_FFFF_FFFC, 64'd1};
    vec[4] = '{MIN, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2};
    vec[5] = '{MIN, ONES, 64'd0, MIN};
`endif

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_dividend_tready", {127'd0, dvd_ready}, 128'd0);
    check("rst_divisor_tready", {127'd0, dsr_ready}, 128'd0);
    check("rst_tvalid", {127'd0, out_valid}, 128'd0);
    check("rst_tdata", out_data, 128'd0);
    check("rst_tuser", {127'd0, out_user}, 128'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("ready_before_first_edge", {126'd0, dvd_ready, dsr_ready}, 128'd0);
    @(negedge aclk);
    check("ready_after_first_edge", {126'd0, dvd_ready, dsr_ready}, 128'd3);

    // Divisor larger than dividend, both presented together
    send(1'b1, 64'd10, 1'b1, 64'd1000, h);
    expect_res(64'd0, 64'd10, 1'b0, h + N + 2, 1'b0);
    wait_drain();

    // Dividend first, divisor five cycles later
    send(1'b1, 64'd1000, 1'b0, 64'd0, h);
    repeat (4) @(posedge aclk);
    @(negedge aclk);
    check("one_side_full_ready", {126'd0, dvd_ready, dsr_ready}, 128'd1);
    send(1'b0, 64'd0, 1'b1, 64'd7, h);
    expect_res(64'd142, 64'd6, 1'b0, h + N + 2, 1'b0);
    wait_drain();

    // Divide by zero
    send(1'b1, 64'h1234, 1'b1, 64'd0, h);
    expect_res(ONES, 64'h1234, 1'b1, h + N + 2, 1'b0);
    wait_drain();

    // Directed value table
    for (int i = 0; i < 6; i++) begin
      send(1'b1, vec[i][0], 1'b1, vec[i][1], h);
      expect_res(vec[i][2], vec[i][3], 1'b0, h + N + 2, 1'b0);
      wait_drain();
    end

    // Backpressure with a second pair buffered behind a stalled result
    out_ready = 1'b0;
    send(1'b1, 64'd200, 1'b1, 64'd9, h);
    expect_res(64'd22, 64'd2, 1'b0, h + N + 2, 1'b0);
    g = 0;
    while (!out_valid && g < 200) begin @(negedge aclk); g++; end
    send(1'b1, 64'd50, 1'b1, 64'd5, h2);
    expect_res(64'd10, 64'd0, 1'b0, 0, 1'b1);
    @(negedge aclk);
    check("buffered_pair_ready_low", {126'd0, dvd_ready, dsr_ready}, 128'd0);
    repeat (20) @(posedge aclk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // Reset during CALC discards the division and a buffered dividend
    send(1'b1, 64'd500, 1'b1, 64'd5, h);
    send(1'b1, 64'd999, 1'b0, 64'd0, hx);
    while (cyc < h + 11) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(negedge aclk);
    check("midop_rst_ready", {126'd0, dvd_ready, dsr_ready}, 128'd0);
    check("midop_rst_tvalid", {127'd0, out_valid}, 128'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    send(1'b1, 64'd100, 1'b1, 64'd3, h);
    expect_res(64'd33, 64'd1, 1'b0, h + N + 2, 1'b0);
    wait_drain();
    repeat (5) @(posedge aclk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000ns, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 64: operand width in bits; even, >= 8.
REQ-002 Parameter BITS_PER_CYCLE, default 1: quotient bits resolved per CALC cycle; 1, 2 or 4; must divide WIDTH.
REQ-003 aclk  input  1  single clock; all logic on rising edge.
REQ-004 aresetn  input  1  asynchronous, active-low reset.
REQ-005 s_axis_divisor_tvalid / s_axis_divisor_tready  input / output  1 / 1  divisor channel handshake.
REQ-006 s_axis_divisor_tdata  input  WIDTH  divisor.
REQ-007 s_axis_dividend_tvalid / s_axis_dividend_tready  input / output  1 / 1  dividend channel handshake.
REQ-008 s_axis_dividend_tdata  input  WIDTH  dividend.
REQ-009 m_axis_dout_tvalid / m_axis_dout_tready  output / input  1 / 1  result handshake; tready provides backpressure.
REQ-010 m_axis_dout_tdata  output  2*WIDTH  {quotient[WIDTH-1:0], remainder[WIDTH-1:0]}; quotient in the upper half.
REQ-011 m_axis_dout_tuser  output  1  divide-by-zero flag for the current result.

Function
REQ-012 Each input channel SHALL have its own one-entry holding register; channel tready = holding register empty, independent of the other channel and of engine state.
REQ-013 A channel transfer SHALL occur on an edge where tvalid and tready are both high; the holding register fills on that edge.
REQ-014 FSM states SHALL be IDLE, CALC, FIX and DONE.
REQ-015 IDLE->CALC SHALL occur on the first edge with both holding registers full; operands load into the engine and both holding registers clear on that same edge.
REQ-016 CALC SHALL last N = WIDTH/BITS_PER_CYCLE cycles, restoring division at BITS_PER_CYCLE bits per cycle; then go to FIX.
REQ-017 FIX SHALL last one cycle (sign correction and result packing), then go to DONE with m_axis_dout_tvalid high.
REQ-018 Latency: with the last operand transfer at edge h, m_axis_dout_tvalid SHALL rise at edge h+N+2; for the defaults this is 66 cycles.
REQ-019 DONE->IDLE SHALL occur on an edge with m_axis_dout_tready high; tdata and tuser SHALL remain stable while tvalid is high and tready is low.
REQ-020 Operands SHALL be accepted into the holding registers during CALC, FIX and DONE; the next division starts only from IDLE.
REQ-021 Divisor == 0: quotient SHALL be all ones, remainder SHALL equal the dividend, tuser SHALL be 1; latency is unchanged.
REQ-022 In all other cases tuser SHALL be 0; quotient and remainder SHALL satisfy dividend = q*divisor + r with |r| < |divisor|.

Reset
REQ-023 While aresetn is low: FSM in IDLE; both holding registers empty; both s tready = 0; m_axis_dout_tvalid = 0; tdata = 0; tuser = 0.
REQ-024 Both s tready SHALL go to 1 on the first aclk edge after aresetn deasserts.
REQ-025 Asserting reset mid-operation SHALL abort the division and discard buffered operands; no result is produced.

Configuration
REQ-026 With SEQ_DIVIDER_SIGNED_EN defined, operands SHALL be two's complement.
REQ-027 In signed mode the quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-028 In signed mode, MIN/-1 SHALL return quotient = MIN, remainder = 0, tuser = 0.
REQ-029 Without SEQ_DIVIDER_SIGNED_EN, operands SHALL be unsigned; FIX SHALL still take one cycle, so latency is identical in both modes.

Structure
REQ-030 Package seq_divider_pkg SHALL hold the FSM state enum and the result-packing offset constants (QUOT_LSB = WIDTH, REM_LSB = 0).
REQ-031 Combinational sub-module seq_divider_step SHALL perform one BITS_PER_CYCLE-bit restoring iteration (partial remainder and quotient bits in, updated values out).

Verification
REQ-032 WIDTH=64: divisor 1000, dividend 10 presented together -> quotient 0, remainder 10, tuser 0, tvalid 66 cycles after transfer.
REQ-033 Dividend 1000 at cycle 0, divisor 7 at cycle 5 -> start on the edge after cycle 5; quotient 142, remainder 6.
REQ-034 Divisor 0, dividend 0x1234 -> quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 0x1234, tuser 1.
REQ-035 m_axis_dout_tready held low for 20 cycles while a second operand pair is sent -> result 1 stays stable; second pair buffered with both tready low; result 2 follows the result-1 handshake by N+2 cycles.
REQ-036 SIGNED_EN: -7/2 -> quotient -2's complement -3, remainder -1; MIN/-1 -> quotient MIN, remainder 0.
REQ-037 aresetn pulsed low at CALC cycle 10 -> no tvalid; tready low during reset; next pair 100/3 -> quotient 33, remainder 1.
